// File: rtl/int_ack_sequencer.sv
// Interrupt acknowledge sequencer: arbitrates a pending NMI against the PIC at
// CPU instruction boundaries, runs the PIC INTA handshake and presents the vector.
module int_ack_sequencer #(
  parameter logic [7:0] NMI_VECTOR = 8'h02
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pic_intr,
  input  logic [7:0] pic_irq,
  output logic       pic_inta,
  input  logic       nmi,
  input  logic       cpu_if,
  input  logic       cpu_boundary,
  output logic       cpu_int_req,
  output logic [7:0] cpu_int_vector,
  output logic       cpu_int_is_nmi,
  input  logic       cpu_int_ack
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    INTA    = 2'd1,
    PRESENT = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       nmi_last_q;
  logic       nmi_pending_q, nmi_pending_d;
  logic [7:0] vector_q, vector_d;
  logic       is_nmi_q, is_nmi_d;
  logic       inta_q;
  logic       req_q;

  logic nmi_edge;
  logic nmi_eff;
  logic nmi_clr;

  // An edge seen in the decision cycle itself already wins over the PIC.
  assign nmi_edge = nmi & ~nmi_last_q;
  assign nmi_eff  = nmi_pending_q | nmi_edge;

  always_comb begin
    state_d  = state_q;
    vector_d = vector_q;
    is_nmi_d = is_nmi_q;
    nmi_clr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_boundary) begin
          if (nmi_eff) begin
            state_d  = PRESENT;
            vector_d = NMI_VECTOR;
            is_nmi_d = 1'b1;
          end else if (cpu_if && pic_intr) begin
            // Sample the PIC vector now; it is not valid once INTA is raised.
            state_d  = INTA;
            vector_d = pic_irq;
            is_nmi_d = 1'b0;
          end
        end
      end
      INTA: state_d = PRESENT;
      PRESENT: begin
        if (cpu_int_ack) begin
          state_d = IDLE;
          nmi_clr = is_nmi_q;
        end
      end
      default: state_d = IDLE;
    endcase
    // Clear-then-set so an edge coinciding with the NMI ack stays pending.
    nmi_pending_d = (nmi_pending_q & ~nmi_clr) | nmi_edge;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      inta_q        <= 1'b0;
      req_q         <= 1'b0;
      vector_q      <= 8'h00;
      is_nmi_q      <= 1'b0;
      nmi_pending_q <= 1'b0;
      nmi_last_q    <= nmi;
    end else begin
      state_q       <= state_d;
      inta_q        <= (state_d == INTA);
      req_q         <= (state_d == PRESENT);
      vector_q      <= vector_d;
      is_nmi_q      <= is_nmi_d;
      nmi_pending_q <= nmi_pending_d;
      nmi_last_q    <= nmi;
    end
  end

  assign pic_inta       = inta_q;
  assign cpu_int_req    = req_q;
  assign cpu_int_vector = vector_q;
  assign cpu_int_is_nmi = is_nmi_q;

endmodule

// File: tb/tb_int_ack_sequencer.sv
// Directed bench for int_ack_sequencer: behavioural delivery model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_int_ack_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pic_intr = 1'b0;
  logic [7:0] pic_irq = 8'h00;
  logic       pic_inta;
  logic       nmi = 1'b0;
  logic       cpu_if = 1'b0;
  logic       cpu_boundary = 1'b0;
  logic       cpu_int_req;
  logic [7:0] cpu_int_vector;
  logic       cpu_int_is_nmi;
  logic       cpu_int_ack = 1'b0;

  int checks = 0;
  int failures = 0;

  int_ack_sequencer #(.NMI_VECTOR(8'h02)) dut (
    .clk(clk), .reset(reset), .pic_intr(pic_intr), .pic_irq(pic_irq),
    .pic_inta(pic_inta), .nmi(nmi), .cpu_if(cpu_if), .cpu_boundary(cpu_boundary),
    .cpu_int_req(cpu_int_req), .cpu_int_vector(cpu_int_vector),
    .cpu_int_is_nmi(cpu_int_is_nmi), .cpu_int_ack(cpu_int_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 = waiting, 1 = acknowledging the PIC, 2 = presenting.
  int         m_phase = 0;
  logic       m_pend = 1'b0;
  logic       m_last = 1'b0;
  logic [7:0] m_vec = 8'h00;
  logic       m_isnmi = 1'b0;
  logic       m_live = 1'b0;

  always @(posedge clk) begin
    logic rise;
    logic clear;
    if (reset) begin
      m_phase = 0; m_pend = 1'b0; m_last = nmi; m_vec = 8'h00; m_isnmi = 1'b0;
      m_live = 1'b1;
    end else begin
      rise  = nmi & ~m_last;
      clear = 1'b0;
      m_last = nmi;
      if (m_phase == 0) begin
        if (cpu_boundary && (m_pend || rise)) begin
          m_phase = 2; m_vec = 8'h02; m_isnmi = 1'b1;
        end else if (cpu_boundary && cpu_if && pic_intr) begin
          m_phase = 1; m_vec = pic_irq; m_isnmi = 1'b0;
        end
      end else if (m_phase == 1) begin
        m_phase = 2;
      end else if (cpu_int_ack) begin
        m_phase = 0;
        clear = m_isnmi;
      end
      m_pend = (m_pend && !clear) || rise;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("model_inta", {7'd0, pic_inta}, {7'd0, m_phase == 1});
      chk("model_req", {7'd0, cpu_int_req}, {7'd0, m_phase == 2});
      if (m_phase == 2) begin
        chk("model_vector", cpu_int_vector, m_vec);
        chk("model_is_nmi", {7'd0, cpu_int_is_nmi}, {7'd0, m_isnmi});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic inta, input logic req);
    chk({name, "_inta"}, {7'd0, pic_inta}, {7'd0, inta});
    chk({name, "_req"}, {7'd0, cpu_int_req}, {7'd0, req});
  endtask

  task automatic expect_vec(input string name, input logic [7:0] vec, input logic isn);
    chk({name, "_vec"}, cpu_int_vector, vec);
    chk({name, "_isnmi"}, {7'd0, cpu_int_is_nmi}, {7'd0, isn});
  endtask

  initial begin
    tick(); tick();
    expect_out("reset", 1'b0, 1'b0);
    expect_vec("reset", 8'h00, 1'b0);
    reset = 1'b0;
    tick();

    // PIC delivery; enables drop mid-delivery without aborting it.
    pic_intr = 1'b1; pic_irq = 8'h0B; cpu_if = 1'b1; cpu_boundary = 1'b1;
    tick();
    expect_out("pic_inta", 1'b1, 1'b0);
    pic_intr = 1'b0; cpu_if = 1'b0; cpu_boundary = 1'b0;
    tick();
    expect_out("pic_present", 1'b0, 1'b1);
    expect_vec("pic_present", 8'h0B, 1'b0);
    tick();
    expect_out("pic_hold", 1'b0, 1'b1);
    cpu_int_ack = 1'b1;
    tick();
    cpu_int_ack = 1'b0;
    expect_out("pic_acked", 1'b0, 1'b0);

    // Interrupts disabled: PIC ignored, NMI still delivered.
    pic_intr = 1'b1; cpu_boundary = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("if0_blocked", 1'b0, 1'b0);
    end
    nmi = 1'b1;
    tick();
    expect_out("nmi_present", 1'b0, 1'b1);
    expect_vec("nmi_present", 8'h02, 1'b1);
    cpu_int_ack = 1'b1;
    tick();
    cpu_int_ack = 1'b0; nmi = 1'b0; pic_intr = 1'b0;
    expect_out("nmi_acked", 1'b0, 1'b0);

    // Stray ack in IDLE.
    cpu_boundary = 1'b0; cpu_int_ack = 1'b1;
    tick();
    cpu_int_ack = 1'b0;
    expect_out("idle_ack", 1'b0, 1'b0);
    tick();

    // NMI and PIC in the same cycle: NMI first, then PIC 0x08.
    pic_intr = 1'b1; pic_irq = 8'h08; cpu_if = 1'b1; cpu_boundary = 1'b1; nmi = 1'b1;
    tick();
    expect_out("prio_nmi", 1'b0, 1'b1);
    expect_vec("prio_nmi", 8'h02, 1'b1);
    cpu_int_ack = 1'b1;
    tick();
    cpu_int_ack = 1'b0;
    expect_out("prio_nmi_ack", 1'b0, 1'b0);
    tick();
    expect_out("prio_pic_inta", 1'b1, 1'b0);
    pic_intr = 1'b0;
    tick();
    expect_out("prio_pic", 1'b0, 1'b1);
    expect_vec("prio_pic", 8'h08, 1'b0);
    cpu_int_ack = 1'b1;
    tick();
    cpu_int_ack = 1'b0; nmi = 1'b0;
    tick();

    // NMI rising during a PIC presentation, held high: exactly one NMI.
    pic_intr = 1'b1; pic_irq = 8'h0B;
    tick();
    pic_intr = 1'b0;
    tick();
    nmi = 1'b1;
    tick();
    expect_vec("late_nmi_pic", 8'h0B, 1'b0);
    cpu_int_ack = 1'b1;
    tick();
    cpu_int_ack = 1'b0;
    expect_out("late_nmi_gap", 1'b0, 1'b0);
    tick();
    expect_out("late_nmi", 1'b0, 1'b1);
    expect_vec("late_nmi", 8'h02, 1'b1);
    cpu_int_ack = 1'b1;
    tick();
    cpu_int_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_out("nmi_level", 1'b0, 1'b0);
    end
    nmi = 1'b0;
    tick();

    // Reset during PRESENT with NMI rising under reset.
    pic_intr = 1'b1; pic_irq = 8'h0B;
    tick();
    expect_out("rst_inta", 1'b1, 1'b0);
    tick();
    reset = 1'b1; nmi = 1'b1; pic_intr = 1'b0;
    tick();
    expect_out("rst_abandon", 1'b0, 1'b0);
    expect_vec("rst_abandon", 8'h00, 1'b0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_out("rst_nmi_level", 1'b0, 1'b0);
    end

    // Edge coinciding with the ack of an NMI stays pending.
    nmi = 1'b0;
    tick();
    nmi = 1'b1;
    tick();
    expect_vec("nmi_a", 8'h02, 1'b1);
    nmi = 1'b0;
    tick();
    nmi = 1'b1; cpu_int_ack = 1'b1;
    tick();
    cpu_int_ack = 1'b0;
    expect_out("nmi_ack_edge", 1'b0, 1'b0);
    tick();
    expect_out("nmi_b", 1'b0, 1'b1);
    expect_vec("nmi_b", 8'h02, 1'b1);
    cpu_int_ack = 1'b1;
    tick();
    cpu_int_ack = 1'b0; nmi = 1'b0;

    // pic_intr drops before any boundary: no INTA.
    cpu_boundary = 1'b0; pic_intr = 1'b1;
    tick();
    pic_intr = 1'b0; cpu_boundary = 1'b1;
    tick(); tick();
    expect_out("intr_drop", 1'b0, 1'b0);

    // Ack during INTA is ignored.
    pic_intr = 1'b1; pic_irq = 8'h21;
    tick();
    pic_intr = 1'b0; cpu_int_ack = 1'b1;
    tick();
    cpu_int_ack = 1'b0;
    expect_out("inta_ack_ignored", 1'b0, 1'b1);
    expect_vec("inta_ack_ignored", 8'h21, 1'b0);
    cpu_int_ack = 1'b1;
    tick();
    cpu_int_ack = 1'b0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
